mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: load/store opcodes and the memory access FSM states.
package mips_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN,
        ST_RESP
    } mau_state_t;

    // Byte count of a load/store opcode; zero marks an unsupported opcode.
    function automatic logic [2:0] op_bytes(input logic [5:0] op);
        logic [2:0] n;
        unique case (1'b1)
            (op == OP_LW) || (op == OP_SW): n = 3'd4;
            (op == OP_LH) || (op == OP_SH): n = 3'd2;
            (op == OP_LB) || (op == OP_SB): n = 3'd1;
            default:                        n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Byte-serial big-endian load/store unit in front of a byte-wide
// synchronous data memory.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [7:0]  mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    mau_state_t  state;
    logic        is_store;
    logic [2:0]  nbytes;
    logic [7:0]  base;
    logic [31:0] wsh;
    logic [2:0]  cnt;
    logic [31:0] result;
    logic        rd_pend;

    logic [2:0]  n_req;
    logic [32:0] last_addr;
    logic        req_bad;
    logic [31:0] rd_next;
    logic [5:0]  align;

    always_comb begin
        n_req     = op_bytes(req_opcode);
        last_addr = {1'b0, req_addr} + 33'(n_req) - 33'd1;
        req_bad   = (n_req == 3'd0) || (last_addr >= 33'(MEM_BYTES));
        rd_next   = rd_pend ? {result[23:0], mem_rdata} : result;
        align     = {3'd4 - nbytes, 3'b000};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            is_store   <= 1'b0;
            nbytes     <= '0;
            base       <= '0;
            wsh        <= '0;
            cnt        <= '0;
            result     <= '0;
            rd_pend    <= 1'b0;
        end else begin
            // A read strobe this cycle means a byte arrives next cycle.
            rd_pend    <= mem_re;
            result     <= rd_next;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ST_ACCESS;
                            is_store <= req_opcode[3];
                            nbytes   <= n_req;
                            base     <= req_addr[7:0];
                            cnt      <= 3'd1;
                            result   <= '0;
                            mem_addr <= req_addr[7:0];
                            wsh      <= req_wdata << 8;
                            if (req_opcode[3]) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata[31:24];
                            end else begin
                                mem_re <= 1'b1;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == nbytes) begin
                        state <= ST_DRAIN;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        mem_addr <= base + {5'd0, cnt};
                        wsh      <= wsh << 8;
                        if (is_store) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= wsh[31:24];
                        end else begin
                            mem_re <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= is_store ? 32'd0 : (rd_next << align);
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    cnt       <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-wide synchronous memory model.
module tb_mem_access_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    bit [7:0] mem [0:255];

    logic        r_we [0:15];
    logic        r_re [0:15];
    logic [7:0]  r_addr [0:15];
    logic [7:0]  r_wd [0:15];
    logic        r_rv [0:15];
    logic        r_err [0:15];
    logic        r_rdy [0:15];
    logic [31:0] r_rd [0:15];

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rec(input int c);
        r_we[c]   = mem_we;
        r_re[c]   = mem_re;
        r_addr[c] = mem_addr;
        r_wd[c]   = mem_wdata;
        r_rv[c]   = resp_valid;
        r_err[c]  = resp_error;
        r_rdy[c]  = req_ready;
        r_rd[c]   = resp_rdata;
    endtask

    // Cycle 0 presents the request; cycles 1..ncyc are recorded #1 after each edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, input int ncyc);
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = hold;
        req_opcode = hold ? 6'b000000 : op;
        for (int c = 1; c <= ncyc; c++) begin
            rec(c);
            if (c >= 2) req_valid = 1'b0;
            if (c < ncyc) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    logic [7:0] sw_b [0:3];

    initial begin
        sw_b[0] = 8'hDE;
        sw_b[1] = 8'hAD;
        sw_b[2] = 8'hBE;
        sw_b[3] = 8'hEF;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_error), 32'd0);
        check("rst_rd", resp_rdata, 32'd0);
        check("rst_strb", {30'd0, mem_re, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(OP_SW, 32'h10, 32'hDEADBEEF, 1'b0, 8);
        check("sw_ready_c1", 32'(r_rdy[1]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sw_we_c%0d", k + 1), 32'(r_we[k+1]), 32'd1);
            check($sformatf("sw_re_c%0d", k + 1), 32'(r_re[k+1]), 32'd0);
            check($sformatf("sw_addr_c%0d", k + 1), {24'd0, r_addr[k+1]}, 32'h10 + k);
            check($sformatf("sw_wd_c%0d", k + 1), {24'd0, r_wd[k+1]}, {24'd0, sw_b[k]});
        end
        check("sw_drain_we", 32'(r_we[5]), 32'd0);
        check("sw_drain_addr", {24'd0, r_addr[5]}, 32'd0);
        check("sw_drain_wd", {24'd0, r_wd[5]}, 32'd0);
        check("sw_rv_c5", 32'(r_rv[5]), 32'd0);
        check("sw_rv_c6", 32'(r_rv[6]), 32'd1);
        check("sw_err_c6", 32'(r_err[6]), 32'd0);
        check("sw_rd_c6", r_rd[6], 32'd0);
        check("sw_rv_c7", 32'(r_rv[7]), 32'd0);
        check("sw_ready_c7", 32'(r_rdy[7]), 32'd1);

        issue(OP_LW, 32'h10, 32'h0, 1'b1, 8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lw_re_c%0d", k + 1), 32'(r_re[k+1]), 32'd1);
            check($sformatf("lw_we_c%0d", k + 1), 32'(r_we[k+1]), 32'd0);
            check($sformatf("lw_addr_c%0d", k + 1), {24'd0, r_addr[k+1]}, 32'h10 + k);
        end
        check("lw_re_c5", 32'(r_re[5]), 32'd0);
        check("lw_rv_c5", 32'(r_rv[5]), 32'd0);
        check("lw_rv_c6", 32'(r_rv[6]), 32'd1);
        check("lw_err_c6", 32'(r_err[6]), 32'd0);
        check("lw_rd_c6", r_rd[6], 32'hDEADBEEF);
        check("lw_hold_c7", r_rd[7], 32'hDEADBEEF);
        check("lw_rv_c7", 32'(r_rv[7]), 32'd0);

        issue(OP_LH, 32'h12, 32'h0, 1'b0, 6);
        check("lh_rv_c3", 32'(r_rv[3]), 32'd0);
        check("lh_rv_c4", 32'(r_rv[4]), 32'd1);
        check("lh_rd_c4", r_rd[4], 32'hBEEF0000);

        issue(OP_LB, 32'h13, 32'h0, 1'b0, 5);
        check("lb_re_c1", 32'(r_re[1]), 32'd1);
        check("lb_re_c2", 32'(r_re[2]), 32'd0);
        check("lb_rv_c3", 32'(r_rv[3]), 32'd1);
        check("lb_rd_c3", r_rd[3], 32'hEF000000);

        issue(OP_LW, 32'hFD, 32'h0, 1'b0, 3);
        check("oob_rv_c1", 32'(r_rv[1]), 32'd1);
        check("oob_err_c1", 32'(r_err[1]), 32'd1);
        check("oob_rd_c1", r_rd[1], 32'd0);
        for (int c = 1; c <= 2; c++)
            check($sformatf("oob_strb_c%0d", c), {30'd0, r_re[c], r_we[c]}, 32'd0);
        check("oob_rv_c2", 32'(r_rv[2]), 32'd0);
        check("oob_ready_c2", 32'(r_rdy[2]), 32'd1);

        issue(OP_SB, 32'hFF, 32'h5A123456, 1'b0, 5);
        check("sb_we_c1", 32'(r_we[1]), 32'd1);
        check("sb_addr_c1", {24'd0, r_addr[1]}, 32'hFF);
        check("sb_wd_c1", {24'd0, r_wd[1]}, 32'h5A);
        check("sb_we_c2", 32'(r_we[2]), 32'd0);
        check("sb_rv_c3", 32'(r_rv[3]), 32'd1);
        check("sb_err_c3", 32'(r_err[3]), 32'd0);

        issue(OP_LB, 32'hFF, 32'h0, 1'b0, 5);
        check("lbff_rd_c3", r_rd[3], 32'h5A000000);

        issue(6'b000000, 32'h0, 32'h0, 1'b0, 3);
        check("bad_rv_c1", 32'(r_rv[1]), 32'd1);
        check("bad_err_c1", 32'(r_err[1]), 32'd1);
        check("bad_rd_c1", r_rd[1], 32'd0);
        check("bad_strb_c1", {30'd0, r_re[1], r_we[1]}, 32'd0);

        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = OP_SW;
        req_addr   = 32'h20;
        req_wdata  = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_sw_we_c1", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        check("rst_sw_addr_c2", {24'd0, mem_addr}, 32'h21);
        reset_n = 1'b0;
        #1;
        check("abort_strb", {30'd0, mem_re, mem_we}, 32'd0);
        check("abort_addr", {24'd0, mem_addr}, 32'd0);
        check("abort_wd", {24'd0, mem_wdata}, 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_rv_%0d", c), 32'(resp_valid), 32'd0);
            check($sformatf("abort_we_%0d", c), 32'(mem_we), 32'd0);
        end

        issue(OP_LW, 32'h20, 32'h0, 1'b0, 7);
        check("post_rv_c6", 32'(r_rv[6]), 32'd1);
        check("post_err_c6", 32'(r_err[6]), 32'd0);
        check("post_rd_c6", r_rd[6], 32'h11000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
